// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder and its fetch-side users.
package imem_pkg;

  function automatic int imem_addr_w(input int mem_bytes);
    return $clog2(mem_bytes);
  endfunction

  localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;
  localparam logic [31:0] NOP_ADDI   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_end;
    logic        misaligned;
  } resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Synchronous first-word-fall-through FIFO; a push and pop in the same cycle is legal even when full.
module resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/imem_responder.sv
// Byte-loaded instruction memory answering fetch PC requests through a fixed-latency pipe and an in-order response FIFO.
module imem_responder
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [31:0]                       req_pc,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [31:0]                       resp_pc,
  output logic [31:0]                       resp_instr,
  output logic                              resp_end,
  output logic                              resp_misaligned,
  input  logic                              load_en,
  input  logic [imem_addr_w(MEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                        load_byte,
  output logic [31:0]                       prog_len,
  output logic                              fetch_complete
);

  localparam int AW = imem_addr_w(MEM_BYTES);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [31:0]   MEM_BYTES_C = 32'(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [31:0]   prog_len_q, prog_len_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          fetch_complete_q, fetch_complete_d;
  logic          accept, pop;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_word;
  logic [31:0]   load_top;
  resp_t         acc_resp;
  logic          push_valid;
  resp_t         push_data;
  resp_t         head;
  logic [$bits(resp_t)-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Credits cover everything in the pipe plus the FIFO, so the FIFO can never overflow.
  assign req_ready = (credits_q < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign pop       = resp_ready && !fifo_empty;

  always_comb begin
    rd_addr = req_pc[AW-1:0];
    rd_word = {mem[rd_addr + AW'(3)], mem[rd_addr + AW'(2)],
               mem[rd_addr + AW'(1)], mem[rd_addr]};
    acc_resp.pc         = req_pc;
    acc_resp.misaligned = |req_pc[1:0];
    // 33-bit sum so a PC near 0xFFFFFFFC cannot wrap below prog_len.
    acc_resp.is_end     = (({1'b0, req_pc} + 33'd4) > {1'b0, prog_len_q}) ||
                          (req_pc >= MEM_BYTES_C);
    acc_resp.instr      = (acc_resp.is_end || acc_resp.misaligned) ? INSTR_ZERO : rd_word;
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    load_top   = 32'(load_addr) + 32'd1;
    prog_len_d = prog_len_q;
    if (load_en && (load_top > prog_len_q)) prog_len_d = load_top;
    fetch_complete_d = fetch_complete_q || (pop && head.is_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q        <= '0;
      prog_len_q       <= '0;
      fetch_complete_q <= 1'b0;
    end else begin
      credits_q        <= credits_d;
      prog_len_q       <= prog_len_d;
      fetch_complete_q <= fetch_complete_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_byte;
  end

  // The pipe holds LATENCY-1 registered stages; the FIFO write supplies the final cycle.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_data  = acc_resp;
    end else begin : g_pipe
      logic  pv_q [LATENCY-1];
      resp_t pd_q [LATENCY-1];

      always_ff @(posedge clk) begin
        pd_q[0] <= acc_resp;
        for (int i = 1; i < LATENCY-1; i++) pd_q[i] <= pd_q[i-1];
        if (reset) begin
          for (int i = 0; i < LATENCY-1; i++) pv_q[i] <= 1'b0;
        end else begin
          pv_q[0] <= accept;
          for (int i = 1; i < LATENCY-1; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      assign push_valid = pv_q[LATENCY-2];
      assign push_data  = pd_q[LATENCY-2];
    end
  endgenerate

  resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_valid && (!fifo_full || pop)),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head            = fifo_rdata;
  assign resp_valid      = (fifo_count != '0);
  assign resp_pc         = resp_valid ? head.pc         : 32'd0;
  assign resp_instr      = resp_valid ? head.instr      : INSTR_ZERO;
  assign resp_end        = resp_valid ? head.is_end     : 1'b0;
  assign resp_misaligned = resp_valid ? head.misaligned : 1'b0;
  assign prog_len        = prog_len_q;
  assign fetch_complete  = fetch_complete_q;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that serves the fetch stage's PC requests and returns little-endian 32-bit instruction words over a valid/ready response channel.
- Holds the program image in a byte array written by a byte-wide loader port.
- Flags end-of-program and drives the sticky fetch_complete signal consumed by TopLevel and its bench.
- Sits between the loader/bench and the fetch unit inside TopLevel.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes (power of two, at least 16)
LATENCY, 2, cycles from request acceptance to earliest response valid (1..4)
DEPTH, 4, maximum requests in flight plus queued responses (power of two, 2..8)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
req_valid  input  1  fetch request present
req_ready  output  1  request may be accepted this cycle
req_pc  input  32  byte address of the requested instruction
resp_valid  output  1  response word present
resp_ready  input  1  fetch stage accepts the response
resp_pc  output  32  PC echoed from the matching request
resp_instr  output  32  instruction word, little-endian assembled
resp_end  output  1  PC is at or beyond the end of the loaded program
resp_misaligned  output  1  req_pc[1:0] != 0
load_en  input  1  write one program byte
load_addr  input  $clog2(MEM_BYTES)  byte address for the write
load_byte  input  8  byte data
prog_len  output  32  highest loaded address + 1
fetch_complete  output  1  sticky; set when a resp_end response handshakes

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: req_ready=1, resp_valid=0, resp_pc=0, resp_instr=0, resp_end=0, resp_misaligned=0, prog_len=0, fetch_complete=0.
- Memory contents are not cleared by reset.
- Request accept: on req_valid & req_ready. Credit counter tracks in-flight plus queued responses; req_ready = (credits < DEPTH).
- Credit counter update: +1 on accept, -1 on resp handshake, unchanged when both occur in the same cycle.
- Pipeline: an accepted request enters a LATENCY-deep shift pipe carrying pc, misaligned, end and read data, then is pushed into a DEPTH-entry response FIFO.
  - Response order equals request order.
  - With an empty FIFO, a request accepted in cycle t shows resp_valid=1 in cycle t+LATENCY.
  - Back-to-back requests stream at 1 per cycle while resp_ready=1.
- Word read: resp_instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]} with a = req_pc mod MEM_BYTES, sampled at acceptance.
- End of program: resp_end=1 when req_pc + 4 > prog_len, or when req_pc >= MEM_BYTES. Use 33-bit compare so there is no wrap at 0xFFFFFFFC. In that case resp_instr = 0.
- Misaligned: resp_misaligned=1, resp_instr = 0; resp_end is still evaluated independently.
- Backpressure: while resp_ready=0, resp_valid/resp_pc/resp_instr/resp_end hold stable. Because of credits the FIFO never overflows.
- Loader: on load_en, mem[load_addr] <= load_byte; prog_len <= max(prog_len, load_addr+1).
  - A request accepted in the same cycle as a write to one of its bytes reads the old byte.
  - The prog_len compare uses the pre-write value.
- fetch_complete: set the cycle after resp_valid & resp_ready & resp_end; cleared only by reset.
- Reset mid-operation: the pipe and FIFO are flushed, credits go to 0, and no stale response appears after reset deasserts.
- Simultaneous FIFO push and pop while full is legal; the count is unchanged.

Decomposition:
- Package imem_pkg:
  - IMEM_ADDR_W function/constant
  - INSTR_ZERO = 32'h0000_0000
  - response payload typedef {pc[31:0], instr[31:0], end, misaligned}
  - constant NOP_ADDI = 32'h0000_0013, for shared use by fetch
- Sub-module: resp_fifo, a synchronous FIFO parameterised on width and DEPTH, with push/pop/full/empty and the count.

Test Plan:
- Load bytes 13 00 00 00 93 00 10 00 at 0..7, then request pc=0 and pc=4 back-to-back with resp_ready=1 -> responses at t+2 and t+3: instr 0x00000013 then 0x00100093, resp_end=0, prog_len=8.
- Request pc=8 after the 8-byte load -> resp_instr=0, resp_end=1; fetch_complete=1 one cycle after the handshake and stays 1.
- Hold resp_ready=0 and stream requests pc=0,4,0,4,... -> req_ready falls after exactly 4 accepts and outputs hold stable; raise resp_ready -> 4 responses in order, then req_ready=1.
- Request pc=2 -> resp_misaligned=1, resp_instr=0, resp_end=0 (prog_len=8).
- In the same cycle, write load_addr=0 byte 0xAA and request pc=0 -> response instr 0x00000013; a later pc=0 request returns 0x000000AA.
- Assert reset for 1 cycle with 3 requests in flight -> resp_valid=0 for the following LATENCY+2 cycles, req_ready=1, fetch_complete=0.
